// File: rtl/cpu_sram_axi_bridge_if.sv
// rtl/cpu_sram_axi_bridge_if.sv - CPU SRAM-like ports and AXI3 master channels of the bridge
// Purpose: bundles the instruction port, the data port and the AXI master channels
//          so the bridge and its environment share one connection point.
// Modports:
//   master - bridge view: samples CPU requests and AXI responses, drives
//            addr_ok/data_ok/rdata and the AXI request channels.
//   slave  - environment view: CPU requester plus AXI memory.
interface cpu_sram_axi_bridge_if;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_sram_axi_bridge.sv
// rtl/cpu_sram_axi_bridge.sv - SRAM-like instruction/data ports to single AXI3 master bridge
// Purpose: accepts one request at a time from the instruction or data port (data wins
//          ties), runs it as a single-beat AXI transfer and returns a one-cycle data_ok.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - synchronous active-high reset, abandons any transfer in flight
//   bus   - cpu_sram_axi_bridge_if.master: CPU request/response and AXI channels
module cpu_sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu_sram_axi_bridge_if.master        bus
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_data_q, owner_data_d;  // 1: data port owns the transfer
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        aw_now, w_now;

  // Read responses are routed by the latched owner, so rid carries no information here.
  logic unused_rid;
  assign unused_rid = ^bus.rid;

  assign bus.arid         = id_q;
  assign bus.araddr       = addr_q;
  assign bus.arsize       = {1'b0, size_q};
  assign bus.arvalid      = (state_q == S_AR);
  assign bus.rready       = (state_q == S_R);
  assign bus.awid         = id_q;
  assign bus.awaddr       = addr_q;
  assign bus.awsize       = {1'b0, size_q};
  assign bus.awvalid      = (state_q == S_AW_W) && !aw_done_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wvalid       = (state_q == S_AW_W) && !w_done_q;
  assign bus.bready       = (state_q == S_B);
  assign bus.inst_data_ok = (state_q == S_RESP) && !owner_data_q;
  assign bus.data_data_ok = (state_q == S_RESP) && owner_data_q;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;

  always_comb begin
    state_d          = state_q;
    owner_data_d     = owner_data_q;
    id_d             = id_q;
    addr_d           = addr_q;
    size_d           = size_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    inst_rdata_d     = inst_rdata_q;
    data_rdata_d     = data_rdata_q;
    aw_now           = 1'b0;
    w_now            = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.data_addr_ok = 1'b0;

    case (state_q)
      S_IDLE: begin
        // No acceptance while reset is held: the request would be dropped unseen.
        if (!reset) begin
          if (bus.data_req) begin
            bus.data_addr_ok = 1'b1;
            owner_data_d     = 1'b1;
            id_d             = DATA_ID;
            addr_d           = bus.data_addr;
            size_d           = bus.data_size;
            wdata_d          = bus.data_wdata;
            wstrb_d          = bus.data_wstrb;
            state_d          = bus.data_wr ? S_AW_W : S_AR;
          end else if (bus.inst_req) begin
            bus.inst_addr_ok = 1'b1;
            owner_data_d     = 1'b0;
            id_d             = INST_ID;
            addr_d           = bus.inst_addr;
            size_d           = bus.inst_size;
            state_d          = S_AR;
          end
        end
      end
      S_AR: begin
        if (bus.arready) state_d = S_R;
      end
      S_R: begin
        if (bus.rvalid) begin
          if (owner_data_q) data_rdata_d = bus.rdata;
          else              inst_rdata_d = bus.rdata;
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        // Address and data handshakes complete independently, possibly together.
        aw_now = aw_done_q || bus.awready;
        w_now  = w_done_q || bus.wready;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_B: begin
        if (bus.bvalid) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_data_q <= 1'b0;
      id_q         <= 4'd0;
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// tb/tb_cpu_sram_axi_bridge.sv - self-checking bench for cpu_sram_axi_bridge
module tb_cpu_sram_axi_bridge;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cpu_sram_axi_bridge_if bus ();

  cpu_sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Transaction-level model: one outstanding request and which of its
  // handshakes have completed so far.
  bit          m_valid = 0;
  bit          m_busy, m_owner, m_wr;
  bit          m_ar_done, m_r_done, m_aw_done, m_w_done, m_b_done;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl();
    return {23'd0, bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok,
            bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready};
  endfunction

  always @(negedge clk) begin : scoreboard
    bit idle, e_iok, e_dok, e_resp, e_arv, e_rr, e_awv, e_wv, e_br;
    idle   = !m_busy;
    e_dok  = idle && !reset && bus.data_req;
    e_iok  = idle && !reset && bus.inst_req && !bus.data_req;
    e_arv  = m_busy && !m_wr && !m_ar_done;
    e_rr   = m_busy && !m_wr && m_ar_done && !m_r_done;
    e_awv  = m_busy && m_wr && !m_aw_done;
    e_wv   = m_busy && m_wr && !m_w_done;
    e_br   = m_busy && m_wr && m_aw_done && m_w_done && !m_b_done;
    e_resp = m_busy && (m_wr ? m_b_done : m_r_done);

    if (m_valid) begin
      check("ctrl", ctrl(), {23'd0, e_iok, e_dok, e_resp && !m_owner, e_resp && m_owner,
                             e_arv, e_rr, e_awv, e_wv, e_br});
      check("inst_rdata", bus.inst_rdata, m_irdata);
      check("data_rdata", bus.data_rdata, m_drdata);
      if (e_arv) begin
        check("araddr", bus.araddr, m_addr);
        check("arsize", 32'(bus.arsize), 32'(m_size));
        check("arid", 32'(bus.arid), m_owner ? 32'd1 : 32'd0);
      end
      if (e_awv) begin
        check("awaddr", bus.awaddr, m_addr);
        check("awsize", 32'(bus.awsize), 32'(m_size));
        check("awid", 32'(bus.awid), 32'd1);
      end
      if (e_wv) begin
        check("wdata", bus.wdata, m_wdata);
        check("wstrb", 32'(bus.wstrb), 32'(m_wstrb));
      end
    end

    // Advance the model across the coming rising edge.
    if (reset) begin
      m_valid = 1; m_busy = 0; m_owner = 0; m_wr = 0;
      m_ar_done = 0; m_r_done = 0; m_aw_done = 0; m_w_done = 0; m_b_done = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_size = 0; m_wstrb = 0;
    end else if (idle) begin
      if (e_dok || e_iok) begin
        m_busy = 1; m_owner = e_dok; m_wr = e_dok && bus.data_wr;
        m_ar_done = 0; m_r_done = 0; m_aw_done = 0; m_w_done = 0; m_b_done = 0;
        m_addr = e_dok ? bus.data_addr : bus.inst_addr;
        m_size = e_dok ? bus.data_size : bus.inst_size;
        if (e_dok) begin
          m_wdata = bus.data_wdata;
          m_wstrb = bus.data_wstrb;
        end
      end
    end else if (e_resp) begin
      m_busy = 0;
    end else if (!m_wr) begin
      if (!m_ar_done) m_ar_done = bus.arready;
      else if (bus.rvalid) begin
        m_r_done = 1;
        if (m_owner) m_drdata = bus.rdata;
        else         m_irdata = bus.rdata;
      end
    end else if (!(m_aw_done && m_w_done)) begin
      m_aw_done = m_aw_done || bus.awready;
      m_w_done  = m_w_done || bus.wready;
    end else if (bus.bvalid) begin
      m_b_done = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.inst_req = 0; bus.data_req = 0;
    bus.arready = 1; bus.awready = 1; bus.wready = 1;
    bus.rvalid = 1; bus.bvalid = 1; bus.rdata = $urandom;
    while (m_busy && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(m_busy), 32'd0);
    bus.rvalid = 0; bus.bvalid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit i_acc = 0, d_acc = 0;
    bus.inst_req = 0; bus.inst_size = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state.
    sample();
    check("rst_ctrl", ctrl(), 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_arid", 32'(bus.arid), 32'd0);
    check("rst_inst_rdata", bus.inst_rdata, 32'd0);
    check("rst_data_rdata", bus.data_rdata, 32'd0);

    // Instruction read, minimum latency.
    step(); bus.inst_req = 1; bus.inst_addr = 32'h1c000000; bus.inst_size = 2; bus.arready = 1;
    sample(); check("t1_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    check("t1_data_addr_ok", 32'(bus.data_addr_ok), 32'd0);
    step(); bus.inst_req = 0;
    sample(); check("t1_arvalid", 32'(bus.arvalid), 32'd1);
    check("t1_araddr", bus.araddr, 32'h1c000000);
    check("t1_arid", 32'(bus.arid), 32'd0);
    step(); bus.rvalid = 1; bus.rdata = 32'h02800421;
    sample(); check("t1_rready", 32'(bus.rready), 32'd1);
    check("t1_early_ok", 32'(bus.inst_data_ok), 32'd0);
    step(); bus.rvalid = 0;
    sample(); check("t1_inst_data_ok", 32'(bus.inst_data_ok), 32'd1);
    check("t1_inst_rdata", bus.inst_rdata, 32'h02800421);
    step();
    sample(); check("t1_ok_pulse_end", 32'(bus.inst_data_ok), 32'd0);
    check("t1_rdata_hold", bus.inst_rdata, 32'h02800421);

    // Simultaneous requests: data first, instruction after data_ok.
    step(); bus.inst_req = 1; bus.inst_addr = 32'h1c000040;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h1c008000; bus.data_size = 2;
    sample(); check("t2_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    check("t2_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
    step(); bus.data_req = 0;
    sample(); check("t2_arid", 32'(bus.arid), 32'd1);
    check("t2_araddr", bus.araddr, 32'h1c008000);
    step(); bus.rvalid = 1; bus.rdata = 32'ha5a50f0f;
    sample();
    step(); bus.rvalid = 0;
    sample(); check("t2_data_data_ok", 32'(bus.data_data_ok), 32'd1);
    check("t2_data_rdata", bus.data_rdata, 32'ha5a50f0f);
    check("t2_inst_wait", 32'(bus.inst_addr_ok), 32'd0);
    step();
    sample(); check("t2_inst_accept", 32'(bus.inst_addr_ok), 32'd1);
    step(); bus.inst_req = 0;
    drain();

    // Write with skewed address and data handshakes.
    bus.data_req = 1; bus.data_wr = 1; bus.data_wstrb = 4'b0011; bus.data_wdata = 32'hdeadbeef;
    bus.data_addr = 32'h1c001000; bus.data_size = 2;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    sample(); check("t3_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    step(); bus.data_req = 0; bus.wready = 1;
    sample(); check("t3_c1_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    check("t3_wdata", bus.wdata, 32'hdeadbeef);
    check("t3_wstrb", 32'(bus.wstrb), 32'h3);
    step(); bus.wready = 0;
    sample(); check("t3_c2_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
    step(); bus.awready = 1;
    sample(); check("t3_c3_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
    step(); bus.awready = 0; bus.bvalid = 1;
    sample(); check("t3_c4_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
    check("t3_bready", 32'(bus.bready), 32'd1);
    step(); bus.bvalid = 0;
    sample(); check("t3_data_data_ok", 32'(bus.data_data_ok), 32'd1);
    check("t3_rdata_kept", bus.data_rdata, 32'ha5a50f0f);
    step();
    sample(); check("t3_ok_pulse_end", 32'(bus.data_data_ok), 32'd0);

    // Stalled read address channel with a competing request waiting.
    step(); bus.inst_req = 1; bus.inst_addr = 32'h1c000100; bus.inst_size = 2; bus.arready = 0;
    sample(); check("t4_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    step(); bus.inst_req = 0; bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h1c008004;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("t4_arvalid", 32'(bus.arvalid), 32'd1);
      check("t4_araddr", bus.araddr, 32'h1c000100);
      check("t4_arid", 32'(bus.arid), 32'd0);
      check("t4_no_accept", 32'(bus.data_addr_ok), 32'd0);
      step();
    end
    bus.data_req = 0;
    drain();

    // Reset while waiting for read data.
    bus.inst_req = 1; bus.inst_addr = 32'h1c000200; bus.arready = 1;
    sample(); check("t5_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    step(); bus.inst_req = 0;
    sample();
    step();
    sample(); check("t5_rready", 32'(bus.rready), 32'd1);
    step(); reset = 1;
    sample();
    step(); reset = 0; bus.rvalid = 1; bus.rdata = 32'h0badc0de;
    sample(); check("t5_after_reset", ctrl(), 32'd0);
    check("t5_inst_rdata", bus.inst_rdata, 32'd0);
    step();
    sample(); check("t5_late_rvalid", ctrl(), 32'd0);
    step(); bus.rvalid = 0;

    // Randomized traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (reset) begin
        bus.inst_req = 0;
        bus.data_req = 0;
      end else begin
        if (!bus.inst_req || i_acc) begin
          bus.inst_req  = ($urandom_range(0, 2) == 0);
          bus.inst_addr = $urandom;
          bus.inst_size = 2'($urandom_range(0, 2));
        end
        if (!bus.data_req || d_acc) begin
          bus.data_req   = ($urandom_range(0, 2) == 0);
          bus.data_wr    = 1'($urandom_range(0, 1));
          bus.data_addr  = $urandom;
          bus.data_size  = 2'($urandom_range(0, 2));
          bus.data_wstrb = 4'($urandom_range(0, 15));
          bus.data_wdata = $urandom;
        end
      end
      bus.arready = 1'($urandom_range(0, 1));
      bus.awready = 1'($urandom_range(0, 1));
      bus.wready  = 1'($urandom_range(0, 1));
      bus.rvalid  = ($urandom_range(0, 2) == 0);
      bus.bvalid  = ($urandom_range(0, 2) == 0);
      bus.rid     = 4'($urandom_range(0, 15));
      bus.rdata   = $urandom;
      sample();
      i_acc = bus.inst_addr_ok;
      d_acc = bus.data_addr_ok;
      step();
    end
    reset = 0;
    drain();
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sram_axi_bridge.md
Name: cpu_sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data memory ports.
- Converts two SRAM-like request/response channels (addr_ok/data_ok handshake) into a single AXI3 master port.
- Arbitrates data over instruction.
- Single-beat transfers, one outstanding transaction at a time.

Parameters:
INST_ID, 4'd0, AXI arid used for instruction reads
DATA_ID, 4'd1, AXI arid/awid used for data reads and writes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req  in  1  instruction read request
- inst_size  in  2  log2 bytes (0/1/2)
- inst_addr  in  32  instruction address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid, one-cycle pulse
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  log2 bytes
- data_wstrb  in  4  byte write enables
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data read data valid or write complete, one-cycle pulse
- data_rdata  out  32  data read data
- arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address channel
- arready  in  1  AXI read address ready
- rid/rdata/rvalid  in  4/32/1  AXI read data channel
- rready  out  1  AXI read data ready
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address channel
- awready  in  1  AXI write address ready
- wdata/wstrb/wvalid  out  32/4/1  AXI write data channel
- wready  in  1  AXI write data ready
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready

Fixed AXI fields are tied constant at the wrapper, not in this block: len=0, burst=2'b01, lock/cache/prot=0, wid=1, wlast=1.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset=1 forces state IDLE from any state.
  - Any in-flight transaction is abandoned on reset; no data_ok is issued for it.
  - Reset values: all valid/ready/addr_ok/data_ok outputs 0, latched address/data/strobe/size/id registers 0, inst_rdata/data_rdata 0.
- States: IDLE, AR, R, AW_W, B, RESP.
- IDLE:
  - addr_ok is combinational and only asserted in IDLE.
  - If data_req: data_addr_ok=1 and inst_addr_ok=0 (data has priority). Latch addr, size, wdata, wstrb, wr, owner=data. Go to AW_W if data_wr, else AR.
  - Else if inst_req: inst_addr_ok=1. Latch with owner=inst. Go to AR.
  - Else stay in IDLE.
- AR:
  - arvalid=1 with araddr = latched addr, arsize = {1'b0, size}, arid = INST_ID or DATA_ID.
  - Outputs held stable until arready. On arvalid&arready, go to R.
- R:
  - rready=1.
  - On rvalid: capture rdata into the owner's rdata register and go to RESP.
  - rid is ignored; routing uses the latched owner.
- AW_W:
  - awvalid and wvalid are asserted together on entry.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Both handshakes in the same cycle is legal.
  - Once both are done, go to B. The flags are cleared on leaving.
  - awsize = {1'b0, size}, wstrb = latched wstrb.
- B:
  - bready=1. On bvalid, go to RESP.
  - bresp is ignored.
- RESP:
  - The owner's data_ok = 1 for exactly one cycle.
  - inst_rdata/data_rdata hold the captured value from RESP until the next capture for that port.
  - For writes, data_data_ok pulses and data_rdata is unchanged.
  - Next state is IDLE. No new request is accepted in RESP.
- Latency:
  - Minimum read, from the addr_ok cycle to the data_ok cycle, is 3 cycles (IDLE → AR → R → RESP) with arready=1 and rvalid in the cycle after the AR handshake.
  - Minimum write is also 3 cycles (IDLE → AW_W → B → RESP).
- Back-to-back: the next addr_ok can be raised at the earliest in the cycle after RESP.
- A request held without acceptance keeps its addr_ok low. The requester must keep req and fields stable until addr_ok.

Test Plan:
- Reset then idle: all outputs 0 and state IDLE. Drive inst_req with inst_addr=0x1c000000 → inst_addr_ok=1 same cycle, arvalid next cycle with araddr=0x1c000000, arid=0.
- Instruction read: arready=1 immediately, rvalid one cycle later with rdata=0x02800421 → inst_data_ok pulses once 3 cycles after addr_ok, inst_rdata=0x02800421.
- Simultaneous requests: inst_req and data_req (read, addr 0x1c008000) in the same cycle → data_addr_ok=1, inst_addr_ok=0, arid=1. The instruction request is accepted in the IDLE after data_data_ok.
- Write with skewed handshakes: data_wr=1, wstrb=4'b0011, wdata=0xdeadbeef; wready at cycle+1, awready at cycle+3 → wvalid drops after cycle+1, awvalid drops after cycle+3. bvalid then yields exactly one data_data_ok pulse.
- Stalled read: arready held 0 for 5 cycles → arvalid, araddr and arid stay constant; no addr_ok is issued for new requests during the stall.
- Reset mid-read: assert reset while in R → next cycle rready=0, state IDLE, no data_ok pulse. A late rvalid after reset is ignored.
